mmio_mem_ctrl: RTL

Second-generation memory controller between the RV32 pipeline and BIOS, IMEM, DMEM and the memory-mapped I/O. It adds byte-lane write masks with store-data alignment, sign/zero-extended sub-word loads, and misalignment detection. It also absorbs the cycle and instruction counters, and adds a parametrised UART TX buffer FIFO so that stores to the UART never stall. LED, switch, button and counter widths are parameters.

---
 rtl/mmio_pkg.sv | 87 ++++++++
 rtl/sync_fifo.sv | 49 ++++
 rtl/mmio_mem_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and pure helpers for the MMIO memory controller: region decode,
// IO register offsets, funct3 encodings, store-lane alignment and load extraction.
package mmio_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {RegNone, RegDmem, RegBios, RegIo} region_e;

  localparam logic [3:0] RegionImemFetch = 4'b0001;
  localparam logic [3:0] RegionBios      = 4'b0100;
  localparam logic [3:0] RegionIo        = 4'b1000;

  localparam logic [31:0] IoStatus   = 32'h8000_0000;
  localparam logic [31:0] IoRxData   = 32'h8000_0004;
  localparam logic [31:0] IoTxData   = 32'h8000_0008;
  localparam logic [31:0] IoTxLevel  = 32'h8000_000C;
  localparam logic [31:0] IoCycles   = 32'h8000_0010;
  localparam logic [31:0] IoInsts    = 32'h8000_0014;
  localparam logic [31:0] IoCntClr   = 32'h8000_0018;
  localparam logic [31:0] IoBtnEmpty = 32'h8000_0020;
  localparam logic [31:0] IoBtnData  = 32'h8000_0024;
  localparam logic [31:0] IoSwitches = 32'h8000_0028;
  localparam logic [31:0] IoLeds     = 32'h8000_0030;

  function automatic logic is_dmem(input logic [3:0] top);
    return (top[3:2] == 2'b00) && top[0];
  endfunction

  function automatic logic is_imem(input logic [3:0] top);
    return top[3:1] == 3'b001;
  endfunction

  // IMEM is write-only from the data side, so it never appears as a load source.
  function automatic region_e load_region(input logic [3:0] top);
    if (is_dmem(top)) return RegDmem;
    if (top == RegionBios) return RegBios;
    if (top == RegionIo) return RegIo;
    return RegNone;
  endfunction

  function automatic logic misaligned_access(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      SB:      return 4'b0001 << off;
      SH:      return off[1] ? 4'b1100 : 4'b0011;
      SW:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      SB:      return {4{wdata[7:0]}};
      SH:      return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      LB:      return {{24{sh[7]}}, sh[7:0]};
      LH:      return {{16{sh[15]}}, sh[15:0]};
      LW:      return word;
      LBU:     return {24'd0, sh[7:0]};
      LHU:     return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; a push while full is dropped even if a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign level   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mmio_mem_ctrl.sv
// Memory controller between the RV32 pipeline and BIOS/IMEM/DMEM/MMIO: byte-lane stores,
// extended sub-word loads, misalignment detection, counters and a buffered UART TX path.
module mmio_mem_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned LED_WIDTH = 6,
  parameter int unsigned SW_WIDTH  = 2,
  parameter int unsigned BTN_WIDTH = 3,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  output logic [31:0]          instruction,
  input  logic [31:0]          ma_pc,
  input  logic [31:0]          ma_addr,
  input  logic [31:0]          ma_wdata,
  input  logic [2:0]           ma_funct3,
  input  logic                 ma_store,
  input  logic                 ma_load,
  input  logic                 inst_retired,
  output logic [31:0]          ma_load_data,
  output logic                 misaligned,
  input  logic [31:0]          bios_outa,
  input  logic [31:0]          bios_outb,
  input  logic [31:0]          dmem_out,
  input  logic [31:0]          imem_outb,
  output logic [3:0]           dmem_we,
  output logic [3:0]           imem_we,
  output logic [31:0]          mem_din,
  output logic [7:0]           uart_din,
  output logic                 uart_din_valid,
  input  logic                 uart_din_ready,
  input  logic [7:0]           uart_dout,
  input  logic                 uart_dout_valid,
  output logic                 uart_dout_ready,
  input  logic                 buttons_fifo_empty,
  input  logic [BTN_WIDTH-1:0] buttons_fifo_data,
  output logic                 buttons_fifo_rd_en,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int unsigned TxLvlW = $clog2(TX_DEPTH) + 1;

  logic [3:0]           ma_top;
  logic [1:0]           ma_off;
  logic [29:0]          io_word;
  logic                 mis, st_ok, ld_ok;
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [TxLvlW-1:0]    tx_level;
  logic                 cnt_clr, led_we, status_rd;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, inst_q, inst_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic                 overflow_q, overflow_d;
  logic [31:0]          io_rdata, rd_io_q, rd_word;
  region_e              rd_region_q, rd_region_d;
  logic [1:0]           rd_off_q;
  logic [2:0]           rd_funct3_q;
  logic                 unused_pc;

  assign unused_pc = ^{ma_pc[31], ma_pc[29:0], if_pc[27:0]};

  assign ma_top  = ma_addr[31:28];
  assign ma_off  = ma_addr[1:0];
  assign io_word = ma_addr[31:2];

  // A simultaneous load+store behaves as a store; the load half is squashed.
  assign mis        = (ma_load || ma_store) && misaligned_access(ma_funct3, ma_off);
  assign misaligned = mis;
  assign st_ok      = ma_store && !mis;
  assign ld_ok      = ma_load && !ma_store && !mis;

  assign mem_din = store_align(ma_funct3, ma_wdata);
  assign dmem_we = (st_ok && is_dmem(ma_top)) ? store_mask(ma_funct3, ma_off) : 4'b0000;
  assign imem_we = (st_ok && is_imem(ma_top) && ma_pc[30]) ? store_mask(ma_funct3, ma_off)
                                                           : 4'b0000;

  always_comb begin
    case (if_pc[31:28])
      RegionImemFetch: instruction = imem_outb;
      RegionBios:      instruction = bios_outb;
      default:         instruction = 32'd0;
    endcase
  end

  assign tx_push            = st_ok && (io_word == IoTxData[31:2]);
  assign cnt_clr            = st_ok && (io_word == IoCntClr[31:2]);
  assign led_we             = st_ok && (io_word == IoLeds[31:2]);
  assign status_rd          = ld_ok && (io_word == IoStatus[31:2]);
  assign uart_dout_ready    = ld_ok && (io_word == IoRxData[31:2]);
  assign buttons_fifo_rd_en = ld_ok && (io_word == IoBtnData[31:2]) && !buttons_fifo_empty;

  assign tx_pop         = !tx_empty && uart_din_ready;
  assign uart_din_valid = !tx_empty;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_push),
    .din  (ma_wdata[7:0]),
    .pop  (tx_pop),
    .dout (uart_din),
    .full (tx_full),
    .empty(tx_empty),
    .level(tx_level)
  );

  // IO snapshot taken at the MA edge, so counters read their pre-increment value.
  always_comb begin
    io_rdata = '0;
    case (io_word)
      IoStatus[31:2]:   io_rdata[2:0] = {overflow_q, uart_dout_valid, !tx_full};
      IoRxData[31:2]:   io_rdata[7:0] = uart_dout;
      IoTxLevel[31:2]:  io_rdata[TxLvlW-1:0] = tx_level;
      IoCycles[31:2]:   io_rdata[CNT_WIDTH-1:0] = cycle_q;
      IoInsts[31:2]:    io_rdata[CNT_WIDTH-1:0] = inst_q;
      IoBtnEmpty[31:2]: io_rdata[0] = buttons_fifo_empty;
      IoBtnData[31:2]:  io_rdata[BTN_WIDTH-1:0] = buttons_fifo_data;
      IoSwitches[31:2]: io_rdata[SW_WIDTH-1:0] = switches;
      IoLeds[31:2]:     io_rdata[LED_WIDTH-1:0] = leds_q;
      default:          io_rdata = '0;
    endcase
  end

  always_comb begin
    cycle_d = cnt_clr ? '0 : cycle_q + 1'b1;
    inst_d  = cnt_clr ? '0 : (inst_retired ? inst_q + 1'b1 : inst_q);
    leds_d  = led_we ? ma_wdata[LED_WIDTH-1:0] : leds_q;
    overflow_d = overflow_q;
    if (status_rd)          overflow_d = 1'b0;
    if (tx_push && tx_full) overflow_d = 1'b1;
    rd_region_d = ld_ok ? load_region(ma_top) : RegNone;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q     <= '0;
      inst_q      <= '0;
      leds_q      <= '0;
      overflow_q  <= 1'b0;
      rd_region_q <= RegNone;
      rd_off_q    <= '0;
      rd_funct3_q <= '0;
      rd_io_q     <= '0;
    end else begin
      cycle_q     <= cycle_d;
      inst_q      <= inst_d;
      leds_q      <= leds_d;
      overflow_q  <= overflow_d;
      rd_region_q <= rd_region_d;
      rd_off_q    <= ma_off;
      rd_funct3_q <= ma_funct3;
      rd_io_q     <= io_rdata;
    end
  end

  always_comb begin
    case (rd_region_q)
      RegDmem: rd_word = dmem_out;
      RegBios: rd_word = bios_outa;
      RegIo:   rd_word = rd_io_q;
      default: rd_word = 32'd0;
    endcase
    ma_load_data = load_extract(rd_funct3_q, rd_off_q, rd_word);
  end

  assign leds = leds_q;

endmodule
